exe_mem_skid_reg: RTL
=====================

EXE_MEM_SKID_REG -- requirements
Module: exe_mem_skid_reg

Interface
REQ-001 The block SHALL be a single-clock design on clk with a synchronous, active-high reset rst sampled only on the rising edge of clk.
REQ-002 Parameter WORD_WIDTH, default 32, SHALL set the ALU result and Rm value width.
REQ-003 Parameter REG_ADDR_LEN, default 4, SHALL set the destination register address width.
REQ-004 Parameter STALL_CNT_W, default 16, SHALL set the stall counter width.
REQ-005 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  discard all held entries
- in_valid  in  1  EXE stage offers an entry
- in_ready  out  1  block can accept an entry
- dst_in  in  REG_ADDR_LEN  destination register
- mem_read_in, mem_write_in, wb_en_in  in  1 each  control bits
- val_rm_in, alu_res_in  in  WORD_WIDTH each  data
- out_valid  out  1  head entry is valid
- out_ready  in  1  MEM stage accepts the head entry
- dst_out  out  REG_ADDR_LEN  head destination
- mem_read_out, mem_write_out, wb_en_out  out  1 each  head control bits, gated by out_valid
- val_rm_out, alu_res_out  out  WORD_WIDTH each  head data
- occupancy  out  2  number of held entries, 0..2
- hz_dst0, hz_wb0  out  REG_ADDR_LEN, 1  head dst and wb_en&valid, for the hazard unit
- hz_dst1, hz_wb1  out  REG_ADDR_LEN, 1  skid dst and wb_en&valid, for the hazard unit
- stall_cnt  out  STALL_CNT_W  saturating count of back-pressure cycles

Function
REQ-006 An input transfer SHALL occur when in_valid and in_ready are both high; an output transfer SHALL occur when out_valid and out_ready are both high.
REQ-007 The block SHALL hold up to two entries, a head (main) register and a skid register, under a 3-state FSM: EMPTY, ONE, TWO.
REQ-008 From EMPTY, an input transfer SHALL load main and move the FSM to ONE.
REQ-009 From ONE, the following SHALL apply:
- input only: load skid and move to TWO.
- output only: move to EMPTY.
- both: load main with the new entry and stay in ONE.
- neither: hold.
REQ-010 From TWO, an output transfer SHALL copy skid into main and move to ONE; otherwise the FSM SHALL hold.
REQ-011 in_ready SHALL be driven directly from a register, equal to (state != TWO), with no combinational path from out_ready.
REQ-012 out_valid SHALL be (state != EMPTY); the head outputs SHALL reflect main with zero added latency.
REQ-013 An entry accepted in cycle N into EMPTY SHALL appear on the outputs in cycle N+1.
REQ-014 mem_read_out, mem_write_out and wb_en_out SHALL read 0 whenever out_valid is 0; data outputs SHALL hold their last value.
REQ-015 Entries SHALL leave the block in the order accepted; no entry SHALL be duplicated or lost, except under flush.
REQ-016 flush SHALL take priority over all transfers: the next state SHALL be EMPTY, and any input offered in the same cycle SHALL be dropped.
REQ-017 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO respectively.
REQ-018 hz_wb0 SHALL be wb_en of main AND out_valid; hz_wb1 SHALL be wb_en of skid AND (state == TWO).
REQ-019 stall_cnt SHALL increment by 1 in each cycle with out_valid=1 and out_ready=0, SHALL saturate at all-ones, and SHALL be unaffected by flush.

Reset
REQ-020 rst SHALL take priority over flush and all transfers.
REQ-021 On rst, the FSM SHALL return to EMPTY, and the following SHALL be 0:
- all data, control and dst registers
- occupancy
- stall_cnt
- hz_* outputs
REQ-022 in_ready SHALL be 1 in the cycle after reset is released; asserting rst mid-operation SHALL discard all held entries.

Structure
REQ-023 The FSM state encoding and the default widths SHALL live in the shared defines package, alongside WORD_WIDTH and REG_FILE_ADDRESS_LEN.
REQ-024 The entry payload register SHALL be one sub-module, exe_mem_entry_reg, with a load enable, instantiated twice (main and skid).

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Reset, then in_valid=1 with alu_res_in=0x0000_1234, dst_in=5, wb_en_in=1, out_ready=1 -> next cycle out_valid=1, alu_res_out=0x0000_1234, hz_dst0=5, hz_wb0=1.
- out_ready=0 while offering A=0x11, then B=0x22 -> occupancy=2, in_ready=0, stall_cnt=2; release out_ready -> A, then B emitted on consecutive cycles.
- ONE state with simultaneous input C=0x33 and output -> occupancy stays 1, head becomes 0x33 next cycle.
- TWO state with flush=1 and in_valid=1 -> next cycle occupancy=0, out_valid=0, wb_en_out=0, input dropped.
- Hold out_ready=0 for 2^STALL_CNT_W+3 cycles with STALL_CNT_W=4 -> stall_cnt saturates at 0xF.
- rst asserted with occupancy=2 -> next cycle all outputs 0, in_ready=1.

Source files
------------

// File: rtl/exe_mem_skid_reg_pkg.sv
// Shared defines for the EXE/MEM skid register: default widths and the
// occupancy FSM encoding.
package exe_mem_skid_reg_pkg;

    localparam int WORD_WIDTH           = 32;
    localparam int REG_FILE_ADDRESS_LEN = 4;
    localparam int STALL_CNT_W_DEF      = 16;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_e;

    function automatic logic [1:0] occupancy_of(input skid_state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/exe_mem_skid_reg_entry.sv
// One EXE/MEM pipeline entry: destination, control bits and data, loaded
// under an enable and cleared on reset.
module exe_mem_entry_reg #(
    parameter int WORD_WIDTH   = 32,
    parameter int REG_ADDR_LEN = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    ld_i,
    input  logic [REG_ADDR_LEN-1:0] dst_i,
    input  logic                    mem_read_i,
    input  logic                    mem_write_i,
    input  logic                    wb_en_i,
    input  logic [WORD_WIDTH-1:0]   val_rm_i,
    input  logic [WORD_WIDTH-1:0]   alu_res_i,
    output logic [REG_ADDR_LEN-1:0] dst_o,
    output logic                    mem_read_o,
    output logic                    mem_write_o,
    output logic                    wb_en_o,
    output logic [WORD_WIDTH-1:0]   val_rm_o,
    output logic [WORD_WIDTH-1:0]   alu_res_o
);

    logic [REG_ADDR_LEN-1:0] dst_q;
    logic                    mem_read_q;
    logic                    mem_write_q;
    logic                    wb_en_q;
    logic [WORD_WIDTH-1:0]   val_rm_q;
    logic [WORD_WIDTH-1:0]   alu_res_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dst_q       <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            wb_en_q     <= 1'b0;
            val_rm_q    <= '0;
            alu_res_q   <= '0;
        end else if (ld_i) begin
            dst_q       <= dst_i;
            mem_read_q  <= mem_read_i;
            mem_write_q <= mem_write_i;
            wb_en_q     <= wb_en_i;
            val_rm_q    <= val_rm_i;
            alu_res_q   <= alu_res_i;
        end
    end

    assign dst_o       = dst_q;
    assign mem_read_o  = mem_read_q;
    assign mem_write_o = mem_write_q;
    assign wb_en_o     = wb_en_q;
    assign val_rm_o    = val_rm_q;
    assign alu_res_o   = alu_res_q;

endmodule

// File: rtl/exe_mem_skid_reg.sv
// Two-entry EXE/MEM skid buffer: head (main) register feeds MEM directly,
// skid register absorbs one extra entry so in_ready can be fully registered.
module exe_mem_skid_reg #(
    parameter int WORD_WIDTH   = exe_mem_skid_reg_pkg::WORD_WIDTH,
    parameter int REG_ADDR_LEN = exe_mem_skid_reg_pkg::REG_FILE_ADDRESS_LEN,
    parameter int STALL_CNT_W  = exe_mem_skid_reg_pkg::STALL_CNT_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_ADDR_LEN-1:0] dst_in,
    input  logic                    mem_read_in,
    input  logic                    mem_write_in,
    input  logic                    wb_en_in,
    input  logic [WORD_WIDTH-1:0]   val_rm_in,
    input  logic [WORD_WIDTH-1:0]   alu_res_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [REG_ADDR_LEN-1:0] dst_out,
    output logic                    mem_read_out,
    output logic                    mem_write_out,
    output logic                    wb_en_out,
    output logic [WORD_WIDTH-1:0]   val_rm_out,
    output logic [WORD_WIDTH-1:0]   alu_res_out,
    output logic [1:0]              occupancy,
    output logic [REG_ADDR_LEN-1:0] hz_dst0,
    output logic                    hz_wb0,
    output logic [REG_ADDR_LEN-1:0] hz_dst1,
    output logic                    hz_wb1,
    output logic [STALL_CNT_W-1:0]  stall_cnt
);
    import exe_mem_skid_reg_pkg::*;

    function automatic logic [STALL_CNT_W-1:0] sat_inc(input logic [STALL_CNT_W-1:0] v);
        if (&v) return v;
        return v + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
    endfunction

    skid_state_e             state_q;
    logic                    in_ready_q;
    logic [STALL_CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    logic                    in_xfer, out_xfer;
    logic                    main_ld, skid_ld, main_from_skid;

    logic [REG_ADDR_LEN-1:0] main_dst_d, main_dst_q, skid_dst_q;
    logic                    main_mr_d, main_mr_q, skid_mr_q;
    logic                    main_mw_d, main_mw_q, skid_mw_q;
    logic                    main_wb_d, main_wb_q, skid_wb_q;
    logic [WORD_WIDTH-1:0]   main_rm_d, main_rm_q, skid_rm_q;
    logic [WORD_WIDTH-1:0]   main_alu_d, main_alu_q, skid_alu_q;

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != ST_EMPTY);
    assign in_xfer   = in_valid && in_ready_q;
    assign out_xfer  = out_valid && out_ready;

    // Head reloads from the input unless the skid entry is waiting behind it.
    always_comb begin
        main_from_skid = (state_q == ST_TWO);
        main_ld        = 1'b0;
        skid_ld        = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_EMPTY: main_ld = in_xfer;
                ST_ONE: begin
                    main_ld = in_xfer && out_xfer;
                    skid_ld = in_xfer && !out_xfer;
                end
                ST_TWO:   main_ld = out_xfer;
                default: ;
            endcase
        end
        main_dst_d = main_from_skid ? skid_dst_q : dst_in;
        main_mr_d  = main_from_skid ? skid_mr_q  : mem_read_in;
        main_mw_d  = main_from_skid ? skid_mw_q  : mem_write_in;
        main_wb_d  = main_from_skid ? skid_wb_q  : wb_en_in;
        main_rm_d  = main_from_skid ? skid_rm_q  : val_rm_in;
        main_alu_d = main_from_skid ? skid_alu_q : alu_res_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else if (flush) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (in_xfer) state_q <= ST_ONE;
                ST_ONE: begin
                    if (in_xfer && !out_xfer) begin
                        state_q    <= ST_TWO;
                        in_ready_q <= 1'b0;
                    end else if (out_xfer && !in_xfer) begin
                        state_q <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (out_xfer) begin
                        state_q    <= ST_ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    // Back-pressure counter ignores flush so stalls stay visible across it.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready) stall_cnt_d = sat_inc(stall_cnt_q);
    end

    always_ff @(posedge clk) begin
        if (rst) stall_cnt_q <= '0;
        else     stall_cnt_q <= stall_cnt_d;
    end

    exe_mem_entry_reg #(.WORD_WIDTH(WORD_WIDTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_main (
        .clk_i(clk), .rst_i(rst), .ld_i(main_ld),
        .dst_i(main_dst_d), .mem_read_i(main_mr_d), .mem_write_i(main_mw_d),
        .wb_en_i(main_wb_d), .val_rm_i(main_rm_d), .alu_res_i(main_alu_d),
        .dst_o(main_dst_q), .mem_read_o(main_mr_q), .mem_write_o(main_mw_q),
        .wb_en_o(main_wb_q), .val_rm_o(main_rm_q), .alu_res_o(main_alu_q)
    );

    exe_mem_entry_reg #(.WORD_WIDTH(WORD_WIDTH), .REG_ADDR_LEN(REG_ADDR_LEN)) u_skid (
        .clk_i(clk), .rst_i(rst), .ld_i(skid_ld),
        .dst_i(dst_in), .mem_read_i(mem_read_in), .mem_write_i(mem_write_in),
        .wb_en_i(wb_en_in), .val_rm_i(val_rm_in), .alu_res_i(alu_res_in),
        .dst_o(skid_dst_q), .mem_read_o(skid_mr_q), .mem_write_o(skid_mw_q),
        .wb_en_o(skid_wb_q), .val_rm_o(skid_rm_q), .alu_res_o(skid_alu_q)
    );

    assign dst_out       = main_dst_q;
    assign mem_read_out  = main_mr_q && out_valid;
    assign mem_write_out = main_mw_q && out_valid;
    assign wb_en_out     = main_wb_q && out_valid;
    assign val_rm_out    = main_rm_q;
    assign alu_res_out   = main_alu_q;
    assign occupancy     = occupancy_of(state_q);
    assign hz_dst0       = main_dst_q;
    assign hz_wb0        = main_wb_q && out_valid;
    assign hz_dst1       = skid_dst_q;
    assign hz_wb1        = skid_wb_q && (state_q == ST_TWO);
    assign stall_cnt     = stall_cnt_q;

endmodule
